// File: rtl/wb_stage_buf.sv
// Write-back stage: result select, sub-word load extraction and a DEPTH-entry result FIFO.
// Optional macro WB_STAGE_FWD_EN enables a forwarding lookup over buffered entries.
module wb_stage_buf #(
  parameter int DEPTH   = 2,
  parameter int WC_W    = 4,
  parameter bit R0_LOCK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WC_W-1:0] in_WC,
  input  logic [31:0]     in_PC,
  input  logic [31:0]     in_PR,
  input  logic [31:0]     in_alu_res,
  input  logic [1:0]      in_S_MXRB,
  input  logic            in_W_RB,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_signed,
  input  logic [1:0]      in_ld_off,
  input  logic            flush,
  input  logic            rf_ready,
  output logic            out_valid,
  output logic [WC_W-1:0] out_WC,
  output logic [31:0]     out_WPC,
  output logic            out_W_RB,
  output logic [31:0]     retired,
  input  logic [WC_W-1:0] fwd_q,
  output logic            fwd_hit,
  output logic [31:0]     fwd_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WC_W-1:0] r_mem_wc   [DEPTH];
  logic [31:0]     r_mem_data [DEPTH];
  logic            r_mem_wrb  [DEPTH];

  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic [WC_W-1:0] r_hold_wc;
  logic [31:0]     r_hold_wpc;
  logic            r_hold_wrb;
  logic [31:0]     r_retired;

  logic [CW-1:0]   w_count_next;
  logic            w_push, w_pop, w_out_valid, w_wrb;
  logic [31:0]     w_byte_sh, w_ld_data, w_wb_data;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_byte_sh = in_PR >> {in_ld_off, 3'b000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = in_ld_off[1] ? in_PR[31:16] : in_PR[15:0];

  always_comb begin
    case (in_ld_size)
      2'd1:    w_ld_data = {{16{in_ld_signed & w_half[15]}}, w_half};
      2'd2:    w_ld_data = {{24{in_ld_signed & w_byte[7]}}, w_byte};
      default: w_ld_data = in_PR;
    endcase
    case (in_S_MXRB)
      2'd0:    w_wb_data = in_alu_res;
      2'd1:    w_wb_data = w_ld_data;
      2'd2:    w_wb_data = in_PC;
      default: w_wb_data = 32'd0;
    endcase
  end

  // Register 0 writes are neutralised here but the entry still flows and retires.
  assign w_wrb = in_W_RB & ~(R0_LOCK & (in_WC == '0));

  assign w_out_valid  = (r_count != '0);
  assign w_push       = in_valid & r_in_ready & ~flush;
  assign w_pop        = w_out_valid & rf_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_wc[r_wr_ptr]   <= in_WC;
      r_mem_data[r_wr_ptr] <= w_wb_data;
      r_mem_wrb[r_wr_ptr]  <= w_wrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
      r_hold_wc  <= '0;
      r_hold_wpc <= '0;
      r_hold_wrb <= 1'b0;
      r_retired  <= '0;
    end else begin
      if (w_pop)
        r_retired <= r_retired + 32'd1;
      // Shadow of the visible head so outputs keep their last value once the buffer drains.
      if (w_out_valid) begin
        r_hold_wc  <= r_mem_wc[r_rd_ptr];
        r_hold_wpc <= r_mem_data[r_rd_ptr];
        r_hold_wrb <= r_mem_wrb[r_rd_ptr];
      end
      if (flush) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_in_ready <= 1'b1;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count    <= w_count_next;
        r_in_ready <= (w_count_next < DEPTH_C);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_WC    = w_out_valid ? r_mem_wc[r_rd_ptr]   : r_hold_wc;
  assign out_WPC   = w_out_valid ? r_mem_data[r_rd_ptr] : r_hold_wpc;
  assign out_W_RB  = w_out_valid ? r_mem_wrb[r_rd_ptr]  : r_hold_wrb;
  assign retired   = r_retired;

`ifdef WB_STAGE_FWD_EN
  // Scan oldest to newest so the newest matching entry overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && r_mem_wrb[r_rd_ptr + PW'(k)] &&
          (r_mem_wc[r_rd_ptr + PW'(k)] == fwd_q)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_mem_data[r_rd_ptr + PW'(k)];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_q;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = 32'd0;
`endif

endmodule

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
Parametrised write-back stage for the processor pipeline. It selects the result source (ALU, data memory, PC) and extracts/extends sub-word loads. It buffers completed results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so a stalled register-file write port no longer back-pressures MEM combinationally. It sits between MEM and the register bank, and also drives an instruction-retire counter.

Parameters:
DEPTH, 2, result buffer entries (power of 2, 2..8)
WC_W, 4, register-address width
R0_LOCK, 1, 1 = writes to register 0 are suppressed (W_RB forced 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
in_valid  in  1  MEM result valid
in_ready  out  1  stage can accept; registered, equals (count < DEPTH)
in_WC  in  WC_W  destination register
in_PC  in  32  PC value for link writes
in_PR  in  32  raw data-memory read word
in_alu_res  in  32  ALU result
in_S_MXRB  in  2  source select: 0 ALU, 1 DM, 2 PC, 3 constant 0
in_W_RB  in  1  register write enable
in_ld_size  in  2  DM size: 0 word, 1 half, 2 byte, 3 word
in_ld_signed  in  1  sign-extend sub-word loads
in_ld_off  in  2  byte offset within word
flush  in  1  synchronous buffer clear
rf_ready  in  1  register-file write port available
out_valid  out  1  head entry valid
out_WC  out  WC_W  head destination register
out_WPC  out  32  head write data
out_W_RB  out  1  head write enable; an actual write occurs only when out_valid && rf_ready && out_W_RB
retired  out  32  count of popped entries, wraps
fwd_q  in  WC_W  forwarding query register (WB_FWD_EN)
fwd_hit  out  1  forwarding hit
fwd_data  out  32  forwarded data

Behaviour:
- Reset (asynchronous): count=0, rd/wr pointers=0, out_valid=0, out_WC/out_WPC/out_W_RB=0, retired=0, in_ready=1 after reset release.
- Push = in_valid && in_ready && !flush. Pop = out_valid && rf_ready.
- Data is formed combinationally from the inputs and stored on push. Latency from push to out_valid = 1 cycle.
- Load extraction, used only when S_MXRB=1:
  - byte: PR[8*off+7:8*off], extended by in_ld_signed.
  - half: off[1]=0 selects PR[15:0], off[1]=1 selects PR[31:16]; off[0] is ignored.
  - word: PR unchanged.
- R0_LOCK=1 and in_WC==0: the stored W_RB is 0. The entry still flows and retires.
- Entries with W_RB=0 are still popped when rf_ready=1 and counted in retired.
- Head outputs come straight from FIFO storage at the rd pointer. out_WC/out_WPC/out_W_RB hold their last value when out_valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==DEPTH): in_ready=0; pop frees a slot and in_ready rises the next cycle.
- Empty: out_valid=0 and pop is impossible.
- Pointers wrap modulo DEPTH.
- retired increments by 1 per pop and wraps 0xFFFFFFFF -> 0.
- flush: next cycle count=0, pointers=0, out_valid=0. Any push that cycle is dropped. A pop in the flush cycle still counts in retired. retired itself is not cleared.
- flush while rf_ready=1: the head is written that cycle (pop occurs) before the clear.

Optional Feature:
WB_STAGE_FWD_EN
- Defined: fwd_hit=1 when any valid buffered entry has W_RB=1 and WC==fwd_q. fwd_data = that entry's data; the newest match (closest to wr pointer) wins. Purely combinational on buffer contents. Entries pushed this cycle are not visible.
- Undefined: fwd_hit=0 and fwd_data=0 constantly; fwd_q is ignored.

Test Plan:
- Reset mid-traffic with 2 entries held -> out_valid=0, retired=0, in_ready=1 immediately after rst drops.
- Push ALU 0x1234_5678, WC=3, W_RB=1, rf_ready=1 -> next cycle out_valid=1, out_WPC=0x12345678, out_WC=3; retired=1 one cycle later.
- DM byte load: PR=0x80FF_7F01, off=2, signed -> out_WPC=0xFFFFFFFF; unsigned off=1 -> 0x0000007F; half off=3 signed -> 0xFFFF80FF.
- rf_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after 2 pushes and the third is held off; raise rf_ready -> entries pop in order, retired +2.
- WC=0, W_RB=1, R0_LOCK=1 -> out_W_RB=0, entry retires; flush with 2 entries and rf_ready=0 -> out_valid=0 next cycle, retired unchanged.
- WB_STAGE_FWD_EN: buffer holds WC=5 data A (old) and WC=5 data B (new), fwd_q=5 -> fwd_hit=1, fwd_data=B; fwd_q=6 -> fwd_hit=0.
